mmr_bank: RTL and testbench
===========================

Name: mmr_bank

Overview:
- Parametrised bank of COUNT memory-mapped registers at consecutive word addresses from BASE.
- Per-register access mode: RW, RO, W1C or WO.
- Successor to the single-register mmr: separate bus in/out data instead of a tristate, registered strobe/ack handshake, error response on illegal access, hardware-side set/load ports.
- Sits between the bus decoder and peripheral control/status logic.

Parameters:
- BASE, 0: word address of register 0.
- COUNT, 4: number of registers, 1..64.
- ABITS, 32: bus address width.
- DBITS, 32: register and bus data width, multiple of 8.
- MODES, 0: packed 2*COUNT bits; field i is mode of register i (0 RW, 1 RO, 2 W1C, 3 WO).
- DEFAULT, 0: packed COUNT*DBITS reset values; field i is register i.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- strobe  in  1  bus request, one transfer per high cycle.
- rw  in  1  1 = write, 0 = read.
- addr  in  ABITS  word address.
- d_in  in  DBITS  bus write data.
- d_out  out  DBITS  bus read data, valid with ack.
- ack  out  1  transfer complete, one cycle after strobe.
- err  out  1  qualifies ack: illegal access.
- hw_we  in  COUNT  per-register hardware load.
- hw_val  in  COUNT*DBITS  hardware load/set data.
- q  out  COUNT*DBITS  current register contents.

Behaviour:
- Reset (async): store[i] <= DEFAULT field i; ack=0, err=0, d_out=0.
- hit = strobe && addr-BASE < COUNT, computed without wrap: addr>=BASE and addr<BASE+COUNT. idx = addr-BASE.
- Latency is exactly 1 cycle:
  - Cycle N: strobe sampled.
  - Cycle N+1: ack=1, err and d_out valid.
  - Back-to-back strobes are each acked, no bubbles, no stall.
- When ack=0, d_out=0 and err=0.
- Read:
  - d_out = store[idx] as of cycle N, before any cycle-N update.
  - WO register reads return 0 with err=0.
  - Miss (strobe, not hit): ack=1, err=1, d_out=0.
- Write, effective at cycle N+1:
  - RW/WO: store <= d_in.
  - RO: no change; ack=1, err=1.
  - W1C: store <= store & ~d_in.
  - Miss: no change; ack=1, err=1.
- Hardware side:
  - hw_we[i] on RW/RO/WO: store[i] <= hw_val field i.
  - hw_we[i] on W1C: store[i] <= store[i] | hw_val field i (sticky set).
- Simultaneous bus write and hw_we to the same register:
  - RW/WO: bus wins.
  - W1C: new = (store & ~d_in) | hw_val; set wins over clear.
  - RO: hw_we applies; bus write still gets err.
- q reflects store combinationally from the flops, updated the cycle after a write.
- Reset asserted mid-transfer: pending ack is dropped; no ack is issued after reset deasserts.
- No internal state machine beyond the 1-deep ack pipeline (ack, err, d_out registers).

Optional Feature:
- Macro: MMR_BANK_BYTE_EN.
- When defined:
  - Adds input be, width DBITS/8.
  - Bus writes update only lanes with be set; W1C clears only within enabled lanes.
  - be=0 write: acked, err=0, no change.
  - Reads ignore be.
- When undefined: no be port; all writes are full-word.

Decomposition:
- Package mmr_pkg:
  - Mode constants MMR_RW=0, MMR_RO=1, MMR_W1C=2, MMR_WO=3.
  - Helper function extracting the mode field of register i from MODES.
- Sub-module mmr_cell (params DBITS, MODE, DEFAULT), instantiated COUNT times in a generate loop.
  - Holds one store register and applies the write, W1C and hw-set rules.
- mmr_bank top holds address decode, err generation, read mux and the ack pipeline.

Test Plan:
- Reset with DEFAULT field0=32'h1234 -> q field0 = 32'h1234, ack=0; read addr BASE -> d_out=32'h1234 one cycle later, ack=1, err=0.
- Write 32'hDEADBEEF to RW reg 1, then read it on the next cycle (back-to-back strobes) -> second ack returns 32'hDEADBEEF; q field1 updates the cycle after the first strobe.
- W1C reg 2:
  - hw_we with 32'hF0 -> store = 32'hF0.
  - Bus write 32'h30 -> store = 32'hC0.
  - Same-cycle bus write 32'hC0 with hw_val 32'h80 -> store = 32'h80.
- Write to RO reg 3, and read at BASE+COUNT -> ack=1, err=1, store unchanged, d_out=0.
- Assert reset in the cycle after a strobe -> no ack ever appears; all stores return to DEFAULT.
- With MMR_BANK_BYTE_EN: write 32'hAABBCCDD, be=4'b0101, to RW reg holding 0 -> store = 32'h00BB00DD.

Source files
------------

// File: rtl/mmr_pkg.sv
// Shared access-mode encodings and mode-field lookup for the mmr_bank register file.
package mmr_pkg;

  localparam logic [1:0] MMR_RW  = 2'd0;
  localparam logic [1:0] MMR_RO  = 2'd1;
  localparam logic [1:0] MMR_W1C = 2'd2;
  localparam logic [1:0] MMR_WO  = 2'd3;

  localparam int unsigned MMR_MAX_COUNT = 64;

  // Mode field of register i from a MODES vector zero-extended to the maximum bank size.
  function automatic logic [1:0] mmr_mode(input logic [2*MMR_MAX_COUNT-1:0] modes,
                                          input int unsigned i);
    return modes[2*i +: 2];
  endfunction

endpackage

// File: rtl/mmr_bank_if.sv
// Bus-side strobe/ack interface of mmr_bank; optional byte enables under MMR_BANK_BYTE_EN.
interface mmr_bank_if #(
  parameter int unsigned ABITS = 32,
  parameter int unsigned DBITS = 32
);
  logic             strobe;
  logic             rw;
  logic [ABITS-1:0] addr;
  logic [DBITS-1:0] d_in;
  logic [DBITS-1:0] d_out;
  logic             ack;
  logic             err;
`ifdef MMR_BANK_BYTE_EN
  logic [DBITS/8-1:0] be;
`endif

  modport master (
    output strobe, rw, addr, d_in,
`ifdef MMR_BANK_BYTE_EN
    output be,
`endif
    input  d_out, ack, err
  );

  modport slave (
    input  strobe, rw, addr, d_in,
`ifdef MMR_BANK_BYTE_EN
    input  be,
`endif
    output d_out, ack, err
  );
endinterface

// File: rtl/mmr_cell.sv
// One mmr_bank register: applies bus write (masked), W1C clear and hardware load/sticky-set.
module mmr_cell import mmr_pkg::*; #(
  parameter int unsigned     DBITS   = 32,
  parameter logic [1:0]      MODE    = MMR_RW,
  parameter logic [DBITS-1:0] DEFAULT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bus_we,
  input  logic [DBITS-1:0] d_in,
  input  logic [DBITS-1:0] wmask,
  input  logic             hw_we,
  input  logic [DBITS-1:0] hw_val,
  output logic [DBITS-1:0] store
);

  logic [DBITS-1:0] store_d, store_q;

  always_comb begin
    store_d = store_q;
    if (MODE == MMR_W1C) begin
      // Clear first, then set, so a same-cycle hardware set is never lost.
      if (bus_we) store_d = store_q & ~(d_in & wmask);
      if (hw_we)  store_d = store_d | hw_val;
    end else if (MODE == MMR_RO) begin
      if (hw_we) store_d = hw_val;
    end else begin
      if (bus_we)     store_d = (store_q & ~wmask) | (d_in & wmask);
      else if (hw_we) store_d = hw_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) store_q <= DEFAULT;
    else       store_q <= store_d;
  end

  assign store = store_q;

endmodule

// File: rtl/mmr_bank.sv
// Bank of COUNT memory-mapped registers with 1-cycle strobe/ack and error response.
// Optional byte-lane write enables when MMR_BANK_BYTE_EN is defined.
module mmr_bank import mmr_pkg::*; #(
  parameter int unsigned             ABITS   = 32,
  parameter int unsigned             DBITS   = 32,
  parameter int unsigned             COUNT   = 4,
  parameter logic [ABITS-1:0]        BASE    = '0,
  parameter logic [2*COUNT-1:0]      MODES   = '0,
  parameter logic [COUNT*DBITS-1:0]  DEFAULT = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  mmr_bank_if.slave              bus,
  input  logic [COUNT-1:0]       hw_we,
  input  logic [COUNT*DBITS-1:0] hw_val,
  output logic [COUNT*DBITS-1:0] q
);

  localparam int unsigned IW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [2*MMR_MAX_COUNT-1:0] ModesX = (2*MMR_MAX_COUNT)'(MODES);

  logic [DBITS-1:0] store_a [COUNT];
  logic [1:0]       mode_a  [COUNT];

  // Compare in ABITS+1 bits so BASE+COUNT cannot wrap.
  logic [ABITS:0] addr_x, base_x, lim_x;
  logic           hit, ro_wr;
  logic [IW-1:0]  idx;
  logic [1:0]     mode_sel;
  logic [DBITS-1:0] wmask;

  assign addr_x   = {1'b0, bus.addr};
  assign base_x   = {1'b0, BASE};
  assign lim_x    = base_x + (ABITS+1)'(COUNT);
  assign hit      = bus.strobe && (addr_x >= base_x) && (addr_x < lim_x);
  assign idx      = IW'(bus.addr - BASE);
  assign mode_sel = mode_a[idx];
  assign ro_wr    = hit && bus.rw && (mode_sel == MMR_RO);

`ifdef MMR_BANK_BYTE_EN
  always_comb begin
    wmask = '0;
    for (int b = 0; b < DBITS / 8; b++) wmask[8*b +: 8] = {8{bus.be[b]}};
  end
`else
  assign wmask = '1;
`endif

  for (genvar i = 0; i < COUNT; i++) begin : g_cell
    localparam logic [1:0] CellMode = mmr_mode(ModesX, i);

    assign mode_a[i] = CellMode;

    mmr_cell #(
      .DBITS   (DBITS),
      .MODE    (CellMode),
      .DEFAULT (DEFAULT[i*DBITS +: DBITS])
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .bus_we (hit && bus.rw && (idx == IW'(i))),
      .d_in   (bus.d_in),
      .wmask  (wmask),
      .hw_we  (hw_we[i]),
      .hw_val (hw_val[i*DBITS +: DBITS]),
      .store  (store_a[i])
    );

    assign q[i*DBITS +: DBITS] = store_a[i];
  end

  logic             ack_q, err_q;
  logic [DBITS-1:0] d_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      d_out_q <= '0;
    end else begin
      ack_q   <= bus.strobe;
      err_q   <= bus.strobe && (!hit || ro_wr);
      d_out_q <= (hit && !bus.rw && (mode_sel != MMR_WO)) ? store_a[idx] : '0;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.d_out = d_out_q;

endmodule

// File: tb/tb_mmr_bank.sv
// Scoreboard bench for mmr_bank: 5 registers (RW, RW, W1C, RO, WO) at word base 0x40.
module tb_mmr_bank;

  localparam int unsigned ABITS = 32;
  localparam int unsigned DBITS = 32;
  localparam int unsigned COUNT = 5;
  localparam logic [31:0] BASE  = 32'h40;
  localparam logic [9:0]  MODES = {2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
  localparam logic [159:0] DEFAULT = {32'h77, 32'h5A5A, 32'h0, 32'h0, 32'h1234};

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   hw_we;
  logic [159:0] hw_val;
  logic [159:0] q;

  mmr_bank_if #(.ABITS(ABITS), .DBITS(DBITS)) bif ();

  mmr_bank #(
    .ABITS   (ABITS),
    .DBITS   (DBITS),
    .COUNT   (COUNT),
    .BASE    (BASE),
    .MODES   (MODES),
    .DEFAULT (DEFAULT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bif.slave),
    .hw_we  (hw_we),
    .hw_val (hw_val),
    .q      (q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m   [5];
  logic [31:0] dfl [5] = '{32'h1234, 32'h0, 32'h0, 32'h5A5A, 32'h77};
  int          md  [5] = '{0, 0, 2, 1, 3};  // RW RW W1C RO WO

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] hv(input int i, input logic [31:0] v);
    return 160'(v) << (32 * i);
  endfunction

  task automatic check_outputs();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("ack", 64'(bif.ack), 64'(1));
      check("err", 64'(bif.err), 64'(e.err));
      check("d_out", 64'(bif.d_out), 64'(e.data));
    end else begin
      check("idle_ack", 64'(bif.ack), 64'(0));
      check("idle_err", 64'(bif.err), 64'(0));
      check("idle_dout", 64'(bif.d_out), 64'(0));
    end
    for (int i = 0; i < 5; i++) check($sformatf("q%0d", i), 64'(q[32*i +: 32]), 64'(m[i]));
  endtask

  // One clock: drive, predict, advance, compare.
  task automatic cycle(input logic stb, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic [4:0] hwe, input logic [159:0] hwv);
    logic [31:0] nm [5];
    logic [31:0] mask;
    logic        hit;
    int          i;
    exp_t        e;
    bif.strobe = stb;
    bif.rw     = wr;
    bif.addr   = a;
    bif.d_in   = d;
`ifdef MMR_BANK_BYTE_EN
    bif.be = b;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
`else
    mask = 32'hFFFF_FFFF;
`endif
    hw_we  = hwe;
    hw_val = hwv;
    hit = (a >= BASE) && (a < BASE + COUNT);
    i   = hit ? int'(a - BASE) : 0;
    if (stb) begin
      if (!hit)    e = '{err: 1'b1, data: 32'h0};
      else if (wr) e = '{err: (md[i] == 1), data: 32'h0};
      else         e = '{err: 1'b0, data: (md[i] == 3) ? 32'h0 : m[i]};
      sb.push_back(e);
    end
    for (int k = 0; k < 5; k++) begin
      logic bw;
      logic [31:0] hk;
      bw = stb && wr && hit && (i == k);
      hk = hwv[32*k +: 32];
      nm[k] = m[k];
      case (md[k])
        2: begin
          if (bw)     nm[k] = nm[k] & ~(d & mask);
          if (hwe[k]) nm[k] = nm[k] | hk;
        end
        1: if (hwe[k]) nm[k] = hk;
        default: begin
          if (bw)          nm[k] = (m[k] & ~mask) | (d & mask);
          else if (hwe[k]) nm[k] = hk;
        end
      endcase
    end
    @(posedge clk);
    #1;
    m = nm;
    bif.strobe = 1'b0;
    hw_we      = '0;
    check_outputs();
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(1'b1, 1'b0, a, 32'h0, 4'hF, 5'b0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d, 4'hF, 5'b0, '0);
  endtask

  initial begin
    reset      = 1'b1;
    bif.strobe = 1'b0;
    bif.rw     = 1'b0;
    bif.addr   = '0;
    bif.d_in   = '0;
`ifdef MMR_BANK_BYTE_EN
    bif.be = 4'hF;
`endif
    hw_we  = '0;
    hw_val = '0;
    for (int k = 0; k < 5; k++) m[k] = dfl[k];
    #1;
    check("rst_q0", 64'(q[31:0]), 64'(32'h1234));
    check("rst_ack", 64'(bif.ack), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs();

    rd(BASE);                                   // default value readback
    wr(BASE + 1, 32'hDEADBEEF);                 // back-to-back write then read
    rd(BASE + 1);
    cycle(1'b0, 1'b0, 0, 0, 4'hF, 5'b00100, hv(2, 32'hF0));
    wr(BASE + 2, 32'h30);
    cycle(1'b1, 1'b1, BASE + 2, 32'hC0, 4'hF, 5'b00100, hv(2, 32'h80));
    rd(BASE + 2);
    wr(BASE + 3, 32'h1111_2222);                // RO write -> err
    rd(BASE + COUNT);                           // miss just above range
    rd(BASE - 1);                               // miss just below range
    wr(BASE + COUNT, 32'hFFFF_FFFF);            // write miss
    rd(BASE + 3);
    wr(BASE + 4, 32'hCAFE);                     // WO write
    rd(BASE + 4);                               // WO read returns 0
    cycle(1'b1, 1'b1, BASE, 32'hAAAA, 4'hF, 5'b00001, hv(0, 32'hBBBB));  // bus wins
    cycle(1'b1, 1'b1, BASE + 3, 32'h1, 4'hF, 5'b01000, hv(3, 32'h3C3C)); // RO: hw applies
    cycle(1'b0, 1'b0, 0, 0, 4'hF, 5'b00010, hv(1, 32'h0102_0304));     // RW hw load
    rd(BASE);
    rd(BASE + 3);
`ifdef MMR_BANK_BYTE_EN
    wr(BASE, 32'h0);
    cycle(1'b1, 1'b1, BASE, 32'hAABBCCDD, 4'b0101, 5'b0, '0);
    check("be_val", 64'(q[31:0]), 64'(32'h00BB00DD));
    cycle(1'b1, 1'b1, BASE, 32'h12345678, 4'b0000, 5'b0, '0);
    cycle(1'b0, 1'b0, 0, 0, 4'hF, 5'b00100, hv(2, 32'hFFFF));
    cycle(1'b1, 1'b1, BASE + 2, 32'hFFFF_FFFF, 4'b0010, 5'b0, '0);
    rd(BASE + 2);
`endif

    // Reset right after a strobe is sampled: the pending ack must vanish.
    bif.strobe = 1'b1;
    bif.rw     = 1'b0;
    bif.addr   = BASE + 1;
    @(posedge clk);
    #1;
    bif.strobe = 1'b0;
    reset      = 1'b1;
    #1;
    check("rst_mid_ack", 64'(bif.ack), 64'(0));
    for (int k = 0; k < 5; k++) m[k] = dfl[k];
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    repeat (3) cycle(1'b0, 1'b0, 0, 0, 4'hF, 5'b0, '0);
    rd(BASE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
